// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and constants for the LED pattern controller.
//   mode_e        - pattern mode selected by cmd_mode
//   state_e       - controller state (IDLE / RUN)
//   DIV_W_DEFAULT - default prescaler width
//   RESET_PATTERN - LED drive after reset
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ROTL   = 2'd0,
    ROTR   = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DIV_W_DEFAULT = 27;
  localparam logic [7:0]  RESET_PATTERN = 8'h01;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step-period prescaler.
//   clk, rst - clock, asynchronous active-high reset
//   clear    - restart the count at 0
//   enable   - count this clock
//   period   - clocks per tick (caller guarantees >= 1)
//   tick     - high in the clock where count == period-1 while enabled
module led_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] count;
  logic             at_end;

  assign at_end = (count == (period - ONE));
  assign tick   = enable && at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_end ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: runs a rotate / bounce / blink sequence on an 8-bit LED port.
//   clk, rst     - clock, asynchronous active-high reset
//   cmd_valid    - command offered; accepted when cmd_ready
//   cmd_ready    - high in IDLE
//   cmd_mode     - 0=ROTL 1=ROTR 2=BOUNCE 3=BLINK
//   cmd_pattern  - initial LED pattern
//   cmd_period   - clocks per step (0 treated as 1)
//   cmd_steps    - number of steps (0 = run until abort)
//   abort        - stop a running sequence, gpio holds
//   gpio         - registered LED drive
//   busy         - high in RUN
//   done         - one-cycle pulse after the final step
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_pattern,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic [7:0]       cmd_steps,
  input  logic             abort,
  output logic [7:0]       gpio,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_e           state, state_nxt;
  mode_e            mode_q;
  logic [DIV_W-1:0] period_q;
  logic [7:0]       remaining;
  logic             dir_left;

  logic             accept;
  logic             run_go;
  logic             tick;
  logic             last_step;
  logic [7:0]       step_pat;
  logic             step_dir_left;

  assign accept    = cmd_valid && (state == IDLE);
  // Abort suppresses the prescaler enable, so a coincident tick never steps.
  assign run_go    = (state == RUN) && !abort;
  assign last_step = tick && (remaining == 8'd1);

  led_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (run_go),
    .period (period_q),
    .tick   (tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (abort || last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == RUN);
  end

  // Pattern for the next step
  always_comb begin
    step_pat      = gpio;
    step_dir_left = dir_left;
    case (mode_q)
      ROTL:  step_pat = {gpio[6:0], gpio[7]};
      ROTR:  step_pat = {gpio[0], gpio[7:1]};
      BLINK: step_pat = ~gpio;
      BOUNCE: begin
        // Hitting an edge reverses direction and steps away from it in the same tick.
        if (dir_left && gpio[7]) begin
          step_dir_left = 1'b0;
          step_pat      = {gpio[0], gpio[7:1]};
        end else if (!dir_left && gpio[0]) begin
          step_dir_left = 1'b1;
          step_pat      = {gpio[6:0], gpio[7]};
        end else if (dir_left) begin
          step_pat      = {gpio[6:0], gpio[7]};
        end else begin
          step_pat      = {gpio[0], gpio[7:1]};
        end
      end
      default: step_pat = gpio;
    endcase
  end

  // Datapath: command latch, pattern stepping, step counter, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio      <= RESET_PATTERN;
      mode_q    <= ROTL;
      period_q  <= ONE;
      remaining <= '0;
      dir_left  <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mode_q    <= mode_e'(cmd_mode);
        period_q  <= (cmd_period == '0) ? ONE : cmd_period;
        remaining <= cmd_steps;
        gpio      <= cmd_pattern;
        dir_left  <= 1'b1;
      end else if (tick) begin
        gpio     <= step_pat;
        dir_left <= step_dir_left;
        // remaining==0 encodes an unbounded run and never counts down.
        if (remaining != '0) remaining <= remaining - 8'd1;
        if (last_step) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: self-checking bench for led_pattern_ctrl.
module tb_led_pattern_ctrl;
  import led_ctrl_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [7:0]   cmd_pattern;
  logic [W-1:0] cmd_period;
  logic [7:0]   cmd_steps;
  logic         abort;
  logic [7:0]   gpio;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.DIV_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_pattern (cmd_pattern),
    .cmd_period  (cmd_period),
    .cmd_steps   (cmd_steps),
    .abort       (abort),
    .gpio        (gpio),
    .busy        (busy),
    .done        (done)
  );

  // Reference model: pattern is a function of (initial pattern, step index k);
  // step index is elapsed clocks / period.
  bit         m_run;
  logic [7:0] m_g;
  logic [7:0] m_p0;
  bit         m_done;
  int         m_mode, m_P, m_steps, m_n;

  function automatic logic [7:0] rot_left(logic [7:0] p, int r);
    logic [15:0] x;
    x = {p, p} << (r % 8);
    return x[15:8];
  endfunction

  function automatic logic [7:0] rot_right(logic [7:0] p, int r);
    return rot_left(p, 8 - (r % 8));
  endfunction

  function automatic logic [7:0] pat_after(int mode, logic [7:0] p, int k);
    logic [7:0] g;
    bit         dl;
    g  = p;
    dl = 1'b1;
    case (mode)
      0: g = rot_left(p, k);
      1: g = rot_right(p, k);
      3: g = (k % 2 == 1) ? ~p : p;
      default: begin
        for (int i = 0; i < k; i++) begin
          if (dl && g[7])       begin dl = 1'b0; g = rot_right(g, 1); end
          else if (!dl && g[0]) begin dl = 1'b1; g = rot_left(g, 1);  end
          else                  g = dl ? rot_left(g, 1) : rot_right(g, 1);
        end
      end
    endcase
    return g;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_g    = 8'h01;
    m_done = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    m_done = 1'b0;
    if (!m_run) begin
      if (cmd_valid) begin
        m_run   = 1'b1;
        m_mode  = int'(cmd_mode);
        m_p0    = cmd_pattern;
        m_P     = (cmd_period == '0) ? 1 : int'(cmd_period);
        m_steps = int'(cmd_steps);
        m_n     = 0;
        m_g     = cmd_pattern;
      end
    end else if (abort) begin
      m_run = 1'b0;
    end else begin
      m_n++;
      if (m_n % m_P == 0) begin
        m_g = pat_after(m_mode, m_p0, m_n / m_P);
        if (m_steps != 0 && m_n / m_P == m_steps) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs();
    check("gpio",      int'(gpio),      int'(m_g));
    check("busy",      int'(busy),      int'(m_run));
    check("cmd_ready", int'(cmd_ready), int'(!m_run));
    check("done",      int'(done),      int'(m_done));
  endtask

  task automatic step_edge();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive_cmd(int mode, logic [7:0] pat, int period, int steps);
    cmd_mode    = 2'(mode);
    cmd_pattern = pat;
    cmd_period  = W'(period);
    cmd_steps   = 8'(steps);
  endtask

  typedef struct {
    int         mode;
    logic [7:0] pat;
    int         period;
    int         steps;
    int         abort_at;   // edge index after accept where abort is seen (0 = never)
    int         cycles;
    logic [7:0] exp_final;
    int         exp_done;
  } vec_t;

  vec_t tbl[4];

  task automatic run_vec(vec_t v);
    int dcount;
    dcount    = 0;
    cmd_valid = 1'b1;
    abort     = 1'b0;
    drive_cmd(v.mode, v.pat, v.period, v.steps);
    step_edge();
    cmd_valid = 1'b0;
    for (int n = 1; n <= v.cycles; n++) begin
      abort = (n == v.abort_at);
      drive_cmd(int'($urandom_range(0, 3)), 8'($urandom), 5, 1);
      step_edge();
      if (done) dcount++;
    end
    abort = 1'b0;
    check("vec_final_gpio", int'(gpio), int'(v.exp_final));
    check("vec_done_count", dcount, v.exp_done);
    check("vec_idle", int'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    drive_cmd(0, 8'h00, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_gpio",  int'(gpio),      8'h01);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy",  int'(busy),      0);
    check("rst_done",  int'(done),      0);

    tbl[0] = '{mode: 0, pat: 8'h01, period: 4, steps: 8,  abort_at: 0, cycles: 34, exp_final: 8'h01, exp_done: 1};
    tbl[1] = '{mode: 2, pat: 8'h01, period: 0, steps: 14, abort_at: 0, cycles: 16, exp_final: 8'h01, exp_done: 1};
    tbl[2] = '{mode: 3, pat: 8'hA5, period: 2, steps: 0,  abort_at: 7, cycles: 10, exp_final: 8'h5A, exp_done: 0};
    tbl[3] = '{mode: 1, pat: 8'h80, period: 3, steps: 0,  abort_at: 3, cycles: 5,  exp_final: 8'h80, exp_done: 0};
    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Zero pattern stays zero under rotation
    run_vec('{mode: 0, pat: 8'h00, period: 1, steps: 5, abort_at: 0, cycles: 7, exp_final: 8'h00, exp_done: 1});

    // Reset in the middle of an unbounded run
    cmd_valid = 1'b1;
    drive_cmd(0, 8'h01, 2, 0);
    step_edge();
    cmd_valid = 1'b0;
    for (int n = 0; n < 5; n++) step_edge();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
    cmd_valid = 1'b1;
    drive_cmd(1, 8'h80, 1, 3);
    step_edge();
    cmd_valid = 1'b0;
    for (int n = 0; n < 4; n++) step_edge();
    check("post_rst_final", int'(gpio), 8'h10);

    // Back-to-back: next command held valid through the run, accepted while done is high
    cmd_valid = 1'b1;
    abort     = 1'b1;   // ignored in IDLE
    drive_cmd(0, 8'h01, 1, 2);
    step_edge();
    abort = 1'b0;
    drive_cmd(3, 8'h0F, 1, 1);
    step_edge();
    step_edge();
    check("b2b_done", int'(done), 1);
    step_edge();
    check("b2b_accept", int'(gpio), 8'h0F);
    step_edge();
    cmd_valid = 1'b0;
    check("b2b_final", int'(gpio), 8'hF0);
    step_edge();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 29) == 0);
      drive_cmd(int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 10)));
      step_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
